// File: rtl/cpu_boot_loader_pkg.sv
// cpu_boot_loader_pkg: shared encodings and helpers for the host-side boot loader.
package cpu_boot_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    localparam int IMEM_STRIDE_DEF = 4;
    localparam int DMEM_STRIDE_DEF = 8;

    // IMEM words are 4-byte aligned, DMEM words 8-byte aligned.
    function automatic logic misaligned(input logic tgt, input logic [2:0] lsb);
        return (tgt == TGT_DMEM) ? (lsb != 3'd0) : (lsb[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/cpu_boot_loader_addr_gen.sv
// loader_addr_gen: write-address walker with per-target stride and remaining-word count.
module loader_addr_gen
    import cpu_boot_loader_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int IMEM_STRIDE = IMEM_STRIDE_DEF,
    parameter int DMEM_STRIDE = DMEM_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             tgt_i,
    input  logic [63:0]      base_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             tgt_o,
    output logic [63:0]      addr_o,
    output logic             last_o
);

    logic [63:0]      addr_q, addr_d, stride;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             tgt_q, tgt_d;

    assign stride = (tgt_q == TGT_DMEM) ? 64'(DMEM_STRIDE) : 64'(IMEM_STRIDE);

    always_comb begin
        addr_d = load_i ? base_i  : step_i ? addr_q + stride   : addr_q;
        rem_d  = load_i ? count_i : step_i ? rem_q - CNT_W'(1) : rem_q;
        tgt_d  = load_i ? tgt_i   : tgt_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            tgt_q  <= TGT_IMEM;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            tgt_q  <= tgt_d;
        end
    end

    assign tgt_o  = tgt_q;
    assign addr_o = addr_q;
    assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: streams host words into the core's IMEM/DMEM external ports, then releases the core.
module cpu_boot_loader
    import cpu_boot_loader_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int IMEM_STRIDE = IMEM_STRIDE_DEF,
    parameter int DMEM_STRIDE = DMEM_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_target,
    input  logic [63:0]      cmd_base,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             dat_valid,
    output logic             dat_ready,
    input  logic [63:0]      dat_word,
    input  logic             go,
    input  logic             halt,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    output logic             cpu_enable,
    output logic             busy,
    output logic             error,
    output logic [63:0]      checksum,
    output logic [CNT_W-1:0] words_written
);

    state_e           state_q;
    logic             init_q, wen_q, wen2_q, cpu_enable_q, error_q;
    logic [63:0]      addr_q, addr2_q, wdata2_q, checksum_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] words_q;
    logic             cmd_fire, ag_tgt, ag_last;
    logic [63:0]      ag_addr, beat;

    // init_q holds ready low for the first cycle after reset release.
    assign cmd_ready = init_q && state_q == IDLE && !halt;
    assign dat_ready = state_q == WRITE && !halt;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat      = (ag_tgt == TGT_IMEM) ? {32'b0, dat_word[31:0]} : dat_word;

    loader_addr_gen #(
        .CNT_W      (CNT_W),
        .IMEM_STRIDE(IMEM_STRIDE),
        .DMEM_STRIDE(DMEM_STRIDE)
    ) u_addr_gen (
        .clk    (clk),
        .arst_n (arst_n),
        .load_i (cmd_fire),
        .step_i (dat_valid && dat_ready),
        .tgt_i  (cmd_target),
        .base_i (cmd_base),
        .count_i(cmd_count),
        .tgt_o  (ag_tgt),
        .addr_o (ag_addr),
        .last_o (ag_last)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            init_q       <= 1'b0;
            wen_q        <= 1'b0;
            wen2_q       <= 1'b0;
            addr_q       <= '0;
            addr2_q      <= '0;
            wdata_q      <= '0;
            wdata2_q     <= '0;
            cpu_enable_q <= 1'b0;
            error_q      <= 1'b0;
            checksum_q   <= '0;
            words_q      <= '0;
        end else begin
            init_q <= 1'b1;
            wen_q  <= 1'b0;
            wen2_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        checksum_q <= '0;
                        words_q    <= '0;
                        if (misaligned(cmd_target, cmd_base[2:0]))
                            error_q <= 1'b1;
                        else if (cmd_count != '0)
                            state_q <= WRITE;
                    end else if (go && init_q && !halt && !cmd_valid) begin
                        state_q      <= RUN;
                        cpu_enable_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (halt) begin
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (dat_valid) begin
                        if (ag_tgt == TGT_DMEM) begin
                            wen2_q   <= 1'b1;
                            addr2_q  <= ag_addr;
                            wdata2_q <= dat_word;
                        end else begin
                            wen_q   <= 1'b1;
                            addr_q  <= ag_addr;
                            wdata_q <= dat_word[31:0];
                        end
                        checksum_q <= checksum_q + beat;
                        words_q    <= words_q + CNT_W'(1);
                        if (ag_last)
                            state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (halt) begin
                        cpu_enable_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_ext      = addr_q;
    assign wen_ext       = wen_q;
    assign ren_ext       = 1'b0;
    assign wdata_ext     = wdata_q;
    assign addr_ext_2    = addr2_q;
    assign wen_ext_2     = wen2_q;
    assign ren_ext_2     = 1'b0;
    assign wdata_ext_2   = wdata2_q;
    assign cpu_enable    = cpu_enable_q;
    assign busy          = state_q != IDLE;
    assign error         = error_q;
    assign checksum      = checksum_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb_cpu_boot_loader: directed stimulus with a write scoreboard drained by an independent monitor.
module tb_cpu_boot_loader;

    localparam int CNT_W = 16;

    typedef struct {
        logic        dmem;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_target = 1'b0;
    logic [63:0]      cmd_base = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             dat_valid = 1'b0, go = 1'b0, halt = 1'b0;
    logic [63:0]      dat_word = '0;
    logic             cmd_ready, dat_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [63:0]      addr_ext, addr_ext_2, wdata_ext_2, checksum;
    logic [31:0]      wdata_ext;
    logic             cpu_enable, busy, error;
    logic [CNT_W-1:0] words_written;

    int  checks = 0;
    int  failures = 0;
    wr_t sb[$];
    logic acc_prev;

    cpu_boot_loader #(.CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_word(dat_word),
        .go(go), .halt(halt),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .error(error),
        .checksum(checksum), .words_written(words_written)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge arst_n)
        if (!arst_n) acc_prev <= 1'b0;
        else acc_prev <= dat_valid && dat_ready;

    // Monitor: every write pulse must match the oldest accepted beat, one cycle after its accept.
    always @(negedge clk) begin
        if (arst_n && (wen_ext || wen_ext_2)) begin
            wr_t e;
            logic [63:0] a, d;
            a = wen_ext ? addr_ext : addr_ext_2;
            d = wen_ext ? {32'b0, wdata_ext} : wdata_ext_2;
            checks++;
            if ((wen_ext && wen_ext_2) || cpu_enable || !acc_prev) begin
                failures++;
                $display("FAIL wr_protocol: wen=%b wen2=%b cpu_enable=%b accept_prev_edge=%b", wen_ext, wen_ext_2, cpu_enable, acc_prev);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: wen=%b wen2=%b addr=%h data=%h", wen_ext, wen_ext_2, a, d);
            end else begin
                e = sb.pop_front();
                if (wen_ext_2 !== e.dmem || a !== e.addr || d !== e.data) begin
                    failures++;
                    $display("FAIL write: got dmem=%b addr=%h data=%h expected dmem=%b addr=%h data=%h", wen_ext_2, a, d, e.dmem, e.addr, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic tgt, input logic [63:0] base, input logic [CNT_W-1:0] cnt);
        logic ok = 1'b0;
        cmd_valid = 1'b1; cmd_target = tgt; cmd_base = base; cmd_count = cnt;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (cmd_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cmd_timeout: cmd_ready=%b expected 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Leaves dat_valid high so beats can be issued back to back.
    task automatic send_beat(input logic [63:0] w, input logic [63:0] exp_addr, input logic dmem);
        logic ok = 1'b0;
        wr_t e;
        dat_valid = 1'b1; dat_word = w;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (dat_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL beat_timeout: dat_ready=%b expected 1", dat_ready);
        end
        @(posedge clk);
        e.dmem = dmem; e.addr = exp_addr; e.data = dmem ? w : {32'b0, w[31:0]};
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #3;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_cpu_enable", cpu_enable, 0);
        chk("rst_error", error, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_words", words_written, 0);
        chk("rst_wen", {wen_ext, wen_ext_2, ren_ext, ren_ext_2}, 0);
        @(negedge clk);
        arst_n = 1'b1;
        #1 chk("ready_first_cycle", cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_release", cmd_ready, 1);

        send_cmd(1'b0, 64'h0, 16'd3);
        chk("imem_busy", busy, 1);
        send_beat(64'h13, 64'h0, 1'b0);
        send_beat(64'h0050_0093, 64'h4, 1'b0);
        send_beat(64'h00A0_0113, 64'h8, 1'b0);
        dat_valid = 1'b0;
        chk("imem_busy_fall", busy, 0);
        chk("imem_checksum", checksum, 64'h0000_0000_00F0_01B9);
        chk("imem_words", words_written, 3);

        send_cmd(1'b1, 64'h40, 16'd2);
        send_beat(64'hDEAD_BEEF_0000_0001, 64'h40, 1'b1);
        dat_valid = 1'b0;
        repeat (3) @(negedge clk);
        send_beat(64'h2, 64'h48, 1'b1);
        dat_valid = 1'b0;
        chk("dmem_checksum", checksum, 64'hDEAD_BEEF_0000_0003);
        chk("dmem_words", words_written, 2);

        send_cmd(1'b0, 64'h2, 16'd4);
        @(negedge clk);
        chk("misalign_error", error, 1);
        chk("misalign_idle", busy, 0);
        send_cmd(1'b1, 64'h0, 16'd0);
        @(negedge clk);
        chk("empty_idle", busy, 0);
        chk("empty_error_sticky", error, 1);
        chk("empty_words", words_written, 0);

        go = 1'b1;
        @(posedge clk); @(negedge clk);
        go = 1'b0;
        chk("run_enable", cpu_enable, 1);
        chk("run_cmd_ready", cmd_ready, 0);
        chk("run_dat_ready", dat_ready, 0);
        halt = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("halt_enable", cpu_enable, 0);
        halt = 1'b0;
        #1 chk("halt_cmd_ready", cmd_ready, 1);
        @(negedge clk);

        send_cmd(1'b0, 64'h100, 16'd4);
        send_beat(64'hAA, 64'h100, 1'b0);
        dat_word = 64'hBB; halt = 1'b1;
        #1 chk("abort_dat_ready", dat_ready, 0);
        @(posedge clk); @(negedge clk);
        halt = 1'b0; dat_valid = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_words", words_written, 1);
        chk("abort_error", error, 1);

        cmd_valid = 1'b1; cmd_target = 1'b1; cmd_base = 64'h200; cmd_count = 16'd1; go = 1'b1;
        #1 chk("prio_cmd_ready", cmd_ready, 1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; go = 1'b0;
        chk("prio_no_enable", cpu_enable, 0);
        chk("prio_write_state", busy, 1);
        send_beat(64'h5, 64'h200, 1'b1);
        dat_valid = 1'b0;
        chk("prio_done", busy, 0);

        send_cmd(1'b1, 64'h300, 16'd3);
        send_beat(64'h7, 64'h300, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_wen", {wen_ext, wen_ext_2}, 0);
        chk("arst_addr", addr_ext_2, 0);
        chk("arst_wdata", wdata_ext_2, 0);
        chk("arst_busy", busy, 0);
        chk("arst_error", error, 0);
        chk("arst_checksum", checksum, 0);
        dat_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        dat_valid = 1'b1; dat_word = 64'h99;
        repeat (4) @(negedge clk);
        dat_valid = 1'b0;
        chk("arst_after_idle", busy, 0);
        chk("arst_after_words", words_written, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
